viral_job_sequencer: RTL
========================

Name: viral_job_sequencer

Overview:
- Front-end controller for the ViRAL encode pipeline.
- Accepts genome job descriptors (start address, length in bases) and fetches each base from a byte-wide genome memory.
- Streams the bases into ViRAL's base-input handshake and terminates each genome with a one-cycle done strobe.
- Tracks genomes in flight through the encoder, counts output chunks per genome, and reports per-job completion.

Parameters:
- BYTE, 8, width of one base / memory word
- ADDR_W, 20, genome memory address width
- LEN_W, 16, job length width (bases)
- MAX_INFLIGHT, 2, maximum genomes fed but not yet fully encoded (ViRAL double-buffering depth)
- CNT_W, 16, output chunk counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accepted when job_valid && job_ready
- job_addr  in  ADDR_W  first base address
- job_len  in  LEN_W  number of bases
- mem_req  out  1  single-cycle read request
- mem_addr  out  ADDR_W  read address
- mem_rvalid  in  1  read data valid (any latency ≥1, one read outstanding)
- mem_rdata  in  BYTE  read data
- v_ready_to_rcv  in  1  ViRAL can accept a base
- v_base_ready  out  1  base valid to ViRAL
- v_base  out  BYTE  base to ViRAL
- v_done  out  1  end-of-genome strobe to ViRAL
- v_o_ready  in  1  ViRAL output chunk valid
- v_o_done  in  1  ViRAL finished one genome's encode
- job_done  out  1  one-cycle completion pulse
- job_chunks  out  CNT_W  chunks emitted for the completed genome; valid with job_done
- job_err  out  1  one-cycle pulse; zero-length descriptor rejected
- busy  out  1  FSM not IDLE or inflight != 0

Behaviour:
- Reset: all outputs 0; FSM=IDLE; inflight=0; chunk_cnt=0; addr and remaining registers 0. Reset mid-job drops the job and does not drive v_done.
- job_ready = (state==IDLE) && (inflight < MAX_INFLIGHT) && !rst.
- FSM states:
  - IDLE: on accept with job_len==0, pulse job_err next cycle and stay IDLE. With job_len>0, latch addr/len and go to FETCH.
  - FETCH: mem_req=1, mem_addr=addr for exactly one cycle, then go to WAIT.
  - WAIT: on mem_rvalid, latch mem_rdata into the base register and go to SEND. Ignore mem_rvalid in any other state.
  - SEND: v_base_ready=1, v_base=held byte while v_ready_to_rcv=0; base and valid held stable. On the cycle v_base_ready && v_ready_to_rcv, decrement remaining and increment addr. If remaining becomes 0, go to FIN, else go to FETCH.
  - FIN: v_done=1 for exactly one cycle, with v_base_ready=0. inflight increments. Go to IDLE.
- Minimum per-base cost: 3 cycles (FETCH, WAIT with 1-cycle memory, SEND with ready).
- v_done is never asserted in the same cycle as v_base_ready.
- inflight:
  - +1 in FIN; −1 on v_o_done when inflight>0.
  - Simultaneous +1/−1 leaves it unchanged.
  - v_o_done with inflight==0 is ignored: no job_done, count unchanged.
- chunk_cnt:
  - +1 on each cycle with v_o_ready=1; saturates at 2^CNT_W−1.
  - On a valid v_o_done, the next cycle pulses job_done with job_chunks = chunk_cnt including a v_o_ready in the same cycle as v_o_done; chunk_cnt clears to 0.
- Address increments wrap modulo 2^ADDR_W.
- Feeding the next job overlaps encode of the previous; the controller blocks only at MAX_INFLIGHT.
- busy = (state!=IDLE) || (inflight!=0).

Test Plan:
- Job addr=0x100, len=3, memory latency 1, v_ready_to_rcv=1 → bases from 0x100..0x102 in order; mem_req seen 3 times; v_done single pulse after 3rd base; inflight=1.
- Same job with v_ready_to_rcv low 5 cycles during 2nd base → v_base/v_base_ready held stable; no extra mem_req; total bases=3.
- Two jobs back-to-back, MAX_INFLIGHT=2, no v_o_done → third job_valid sees job_ready=0 until v_o_done; then accepted; inflight returns to 2.
- Drive v_o_ready 4 cycles, then v_o_done with v_o_ready high → job_done pulse with job_chunks=5; counter clears.
- job_len=0 → job_err one pulse; no mem_req, no v_done; inflight unchanged. Spurious v_o_done at inflight=0 → no job_done.
- Assert rst while in SEND → next cycle all outputs 0, FSM IDLE, inflight 0; new job runs normally afterward. Job at addr=0xFFFFF, len=2 → second read at 0x00000.

Source files
------------

// File: rtl/viral_job_sequencer.sv
// Purpose: fetches each genome job's bases from byte memory and streams them into ViRAL, then tracks encode completion per genome.
// Latency: at least 3 cycles per base (fetch, wait, send); job_done/job_err pulse one cycle after the triggering event.
// Backpressure: holds v_base/v_base_ready while v_ready_to_rcv is low; refuses new jobs while feeding or at MAX_INFLIGHT.
module viral_job_sequencer #(
   parameter int BYTE         = 8,
   parameter int ADDR_W       = 20,
   parameter int LEN_W        = 16,
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [ADDR_W-1:0] job_addr,
   input  logic [LEN_W-1:0]  job_len,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [BYTE-1:0]   mem_rdata,
   input  logic              v_ready_to_rcv,
   output logic              v_base_ready,
   output logic [BYTE-1:0]   v_base,
   output logic              v_done,
   input  logic              v_o_ready,
   input  logic              v_o_done,
   output logic              job_done,
   output logic [CNT_W-1:0]  job_chunks,
   output logic              job_err,
   output logic              busy
);

   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_INFLIGHT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_SEND  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [BYTE-1:0]   base;
   logic [INF_W-1:0]  inflight;
   logic [CNT_W-1:0]  chunk_cnt;
   logic [CNT_W-1:0]  chunk_nxt;
   logic              accept;
   logic              send_fire;
   logic              inf_inc;
   logic              inf_dec;

   assign job_ready = (state == S_IDLE) && (inflight < MAX_INF) && !rst;
   assign accept    = job_valid && job_ready;
   assign send_fire = (state == S_SEND) && v_ready_to_rcv;
   assign inf_inc   = (state == S_FIN);
   // a completion with nothing in flight is spurious and ignored
   assign inf_dec   = v_o_done && (inflight != '0);
   // chunk counter sticks at all-ones rather than wrapping
   assign chunk_nxt = (v_o_ready && (chunk_cnt != '1)) ? chunk_cnt + CNT_W'(1) : chunk_cnt;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state: one fetch/wait/send round per base, then a single FIN cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && (job_len != '0)) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT:  if (mem_rvalid) state_nxt = S_SEND;
         S_SEND:  if (v_ready_to_rcv) state_nxt = (remaining == LEN_W'(1)) ? S_FIN : S_FETCH;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs; data buses are zeroed when not qualified
   always_comb begin
      mem_req      = (state == S_FETCH);
      mem_addr     = (state == S_FETCH) ? addr : '0;
      v_base_ready = (state == S_SEND);
      v_base       = (state == S_SEND) ? base : '0;
      v_done       = (state == S_FIN);
      busy         = (state != S_IDLE) || (inflight != '0);
   end

   // job datapath: address/length latch, per-base advance, read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         addr      <= '0;
         remaining <= '0;
         base      <= '0;
      end else begin
         if (accept && (job_len != '0)) begin
            addr      <= job_addr;
            remaining <= job_len;
         end else if (send_fire) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
         end
         if ((state == S_WAIT) && mem_rvalid) base <= mem_rdata;
      end
   end

   // zero-length descriptors are consumed and flagged
   always_ff @(posedge clk) begin
      if (rst) job_err <= 1'b0;
      else     job_err <= accept && (job_len == '0);
   end

   // genomes fed to ViRAL but not yet reported done
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else if (inf_inc && !inf_dec) begin
         inflight <= inflight + INF_W'(1);
      end else if (!inf_inc && inf_dec) begin
         inflight <= inflight - INF_W'(1);
      end
   end

   // chunk counting and completion report; a chunk arriving with v_o_done is included
   always_ff @(posedge clk) begin
      if (rst) begin
         chunk_cnt  <= '0;
         job_done   <= 1'b0;
         job_chunks <= '0;
      end else if (inf_dec) begin
         chunk_cnt  <= '0;
         job_done   <= 1'b1;
         job_chunks <= chunk_nxt;
      end else begin
         chunk_cnt  <= chunk_nxt;
         job_done   <= 1'b0;
         job_chunks <= '0;
      end
   end

endmodule
